// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier:
// controller state encoding and the bit-counter width function.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes the N multiplier bits (0..N-1).
    function automatic int count_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/bit_multiplier.sv
// Single partial-product stage: the multiplicand gated by one multiplier bit.
module bit_multiplier #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic         b_bit,
    output logic [N-1:0] pp
);

    assign pp = a & {N{b_bit}};

endmodule

// File: rtl/seq_multiplier_ctrl.sv
// Sequential shift-add multiplier controller, one multiplier bit per clock.
// Optional feature: SEQ_MULT_EARLY_EXIT_EN ends RUN once no set bits remain in b.
module seq_multiplier_ctrl
    import mult_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] p
);

    localparam int CW = count_w(N);

    state_t          state;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic [2*N-1:0]  acc;
    logic [CW-1:0]   count;
    logic [N-1:0]    pp;
    logic [2*N-1:0]  sum;
    logic            last;

    bit_multiplier #(.N(N)) u_bit_multiplier (
        .a     (a_reg),
        .b_bit (b_reg[0]),
        .pp    (pp)
    );

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch to hold the missing case.
    always_comb begin
        sum  = acc + ({{N{1'b0}}, pp} << count);
        last = (count == CW'(N - 1));
`ifdef SEQ_MULT_EARLY_EXIT_EN
        if ((b_reg >> 1) == '0) begin
            last = 1'b1;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            acc   <= '0;
            count <= '0;
            p     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= sum;
                    b_reg <= b_reg >> 1;
                    count <= count + 1'b1;
                    if (last) begin
                        // p only ever sees a finished product.
                        p     <= sum;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_ctrl.sv
// Scoreboard bench for seq_multiplier_ctrl (N=4): stimulus pushes expected
// products and latencies, a monitor pops and compares on every done pulse.
module tb_seq_multiplier_ctrl;

    localparam int N = 4;

    typedef struct {
        logic [2*N-1:0] p;
        int             acc_cyc;
        int             lat;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] p;

    exp_t           sb[$];
    int             total;
    int             bad;
    int             cyc;
    logic [2*N-1:0] held_p;

    seq_multiplier_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected RUN length: fixed N, or highest-set-bit index + 1 with early exit.
    function automatic int lat(input int on_lat);
`ifdef SEQ_MULT_EARLY_EXIT_EN
        return on_lat;
`else
        return (on_lat > 0) ? N : N;
`endif
    endfunction

    // Monitor: compares product and latency on done, and p holding otherwise.
    initial begin
        exp_t e;
        held_p = '0;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                sb.delete();
                held_p = '0;
                if (!clk) check("p_in_reset", int'(p), 0);
            end else if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("product", int'(p), int'(e.p));
                    check("latency", cyc - e.acc_cyc, e.lat);
                    held_p = e.p;
                end
            end else begin
                check("p_hold", int'(p), int'(held_p));
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy && rst_n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 1, 0);
    endtask

    // Issue one operation; optionally measure how long busy stays high.
    task automatic do_op(input int av, input int bv, input int pv, input int on_lat,
                         input bit busy_chk);
        exp_t e;
        int   n;
        wait_idle();
        a     = N'(av);
        b     = N'(bv);
        start = 1'b1;
        e.p       = (2*N)'(pv);
        e.acc_cyc = cyc + 1;
        e.lat     = lat(on_lat);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~a;
        b     = ~b;
        if (busy_chk) begin
            n = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (busy) n++;
                else break;
            end
            check("busy_cycles", n, lat(on_lat) + 1);
        end
    endtask

    initial begin
        exp_t e;
        int   first_acc;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        #12;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_p", int'(p), 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(13, 11, 143, 4, 1'b1);
        do_op(15, 15, 225, 4, 1'b0);
        wait_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_done_low", int'(done), 0);
            check("hold_p", int'(p), 225);
        end
        do_op(0, 9, 0, 4, 1'b0);
        do_op(9, 0, 0, 1, 1'b1);

        // start held high; operands churn during RUN and must be ignored.
        wait_idle();
        a     = 4'd6;
        b     = 4'd7;
        start = 1'b1;
        e.p       = 8'd42;
        e.acc_cyc = cyc + 1;
        e.lat     = lat(3);
        first_acc = e.acc_cyc;
        sb.push_back(e);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
            a = N'($urandom_range(0, 15));
            b = N'($urandom_range(0, 15));
        end
        a = 4'd5;
        b = 4'd3;
        e.p       = 8'd15;
        e.acc_cyc = cyc + 1;
        e.lat     = lat(2);
        sb.push_back(e);
        check("back_to_back_gap", e.acc_cyc - first_acc, lat(3) + 2);
        @(posedge clk);
        #1;
        start = 1'b0;

        // Reset asserted mid-RUN at E2 abandons the operation.
        wait_idle();
        a     = 4'd7;
        b     = 4'd6;
        start = 1'b1;
        e.p       = 8'd42;
        e.acc_cyc = cyc + 1;
        e.lat     = lat(3);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_done", int'(done), 0);
        check("async_rst_p", int'(p), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("post_rst_busy", int'(busy), 0);
        end
        do_op(3, 3, 9, 2, 1'b0);

        do_op(7, 1, 7, 1, 1'b1);
        do_op(7, 8, 56, 4, 1'b1);

        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
